// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmitter.
// Grants one byte requester at a time and sequences send/active/done.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 1,
  parameter int START_TIMEOUT = 4,
  parameter int DONE_TIMEOUT  = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CM0 = (DONE_TIMEOUT > START_TIMEOUT) ?
                       DONE_TIMEOUT : START_TIMEOUT;
  localparam int CMAX = (CM0 > GAP_CYCLES) ? CM0 : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WSTART,
    S_WDONE,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LW-1:0]      r_last;
  logic [LW-1:0]      r_idx;
  logic [LW-1:0]      w_win;
  logic [LW-1:0]      w_cand;
  logic               w_found;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_data;
  logic               w_load;
  logic               w_clr;
  logic               w_upd;

  // Search starts just past the last served requester.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = LW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt       = r_cnt;
    tx_send     = 1'b0;
    ack         = '0;
    timeout_err = 1'b0;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_upd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load = 1'b1;
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        tx_send = 1'b1;
        w_cnt   = '0;
        w_next  = S_WSTART;
      end
      S_WSTART: begin
        if (tx_active) begin
          w_cnt  = '0;
          w_next = S_WDONE;
        end else if (r_cnt == CW'(START_TIMEOUT)) begin
          timeout_err = 1'b1;
          w_clr       = 1'b1;
          w_cnt       = '0;
          w_next      = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_WDONE: begin
        if (!tx_active && tx_done) begin
          ack    = r_grant;
          w_clr  = 1'b1;
          w_upd  = 1'b1;
          w_cnt  = '0;
          w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (r_cnt == CW'(DONE_TIMEOUT)) begin
          timeout_err = 1'b1;
          w_clr       = 1'b1;
          w_cnt       = '0;
          w_next      = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt + 1'b1 >= CW'(GAP_CYCLES)) begin
          w_cnt  = '0;
          w_next = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_data  <= 8'h00;
      r_idx   <= '0;
      r_last  <= LW'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_load) begin
        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
        r_data  <= req_data[{w_win, 3'b000} +: 8];
        r_idx   <= w_win;
      end else if (w_clr) begin
        r_grant <= '0;
      end
      if (w_upd) begin
        r_last <= r_idx;
      end
    end
  end

  assign grant   = r_grant;
  assign tx_data = r_data;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a frame-level reference
// model of rotating priority and transmitter handshake timing.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 1;
  localparam int STO = 4;
  localparam int DTO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_active;
  logic           tx_done;
  logic           busy;
  logic           timeout_err;

  logic [7:0] dat [N];
  int n_chk = 0;
  int n_err = 0;
  int m_last;
  int cur;
  bit arr_en;
  int w;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  end

  uart_tx_arbiter #(
    .NUM_REQ(N), .GAP_CYCLES(GAP),
    .START_TIMEOUT(STO), .DONE_TIMEOUT(DTO)
  ) dut (
    .baud_clk(clk), .reset_n(rst_n),
    .req(req), .req_data(req_data),
    .ack(ack), .grant(grant),
    .tx_send(tx_send), .tx_data(tx_data),
    .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (arr_en)
      for (int i = 0; i < N; i++)
        if (!req[i] && i != cur && $urandom_range(0, 15) == 0) begin
          dat[i] = 8'($urandom);
          req[i] = 1'b1;
        end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    cur = -1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to", timeout_err, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_last = N - 1;
    #1;
  endtask

  // mode: 0 normal, 1 start timeout, 2 done timeout, 3 reset mid-frame
  task automatic frame(input int mode, input int d, input int len,
                       input bit drop, input bit rearm,
                       output int won);
    int wi;
    int nl;
    logic [7:0] ed;
    logic [N-1:0] oh;
    if (req == '0) begin
      wi = $urandom_range(0, N - 1);
      dat[wi] = 8'($urandom);
      req[wi] = 1'b1;
    end
    #1;
    wi = pick(m_last, req);
    won = wi;
    cur = wi;
    ed = dat[wi];
    oh = N'(1) << wi;
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
    tick();
    tx_active = 1'b0;
    tx_done = 1'b0;
    #1;
    chk("send_grant", grant, oh);
    chk("send_data", tx_data, ed);
    chk("send_strobe", tx_send, 1);
    chk("send_busy", busy, 1);
    if (mode == 1) begin
      for (int i = 0; i <= STO; i++) begin
        tick();
        #1;
        chk("ws_send", tx_send, 0);
        chk("ws_grant", grant, oh);
        chk("ws_ack", ack, 0);
        chk("ws_to", timeout_err, i == STO);
      end
      tick();
      #1;
      chk("sto_busy", busy, 0);
      chk("sto_grant", grant, 0);
      chk("sto_to", timeout_err, 0);
      cur = -1;
      return;
    end
    for (int i = 0; i < d; i++) begin
      tick();
      #1;
      chk("dly_send", tx_send, 0);
      chk("dly_to", timeout_err, 0);
      chk("dly_grant", grant, oh);
    end
    nl = (mode == 2) ? 1 + DTO : len;
    for (int i = 0; i < nl; i++) begin
      tick();
      tx_active = 1'b1;
      tx_done = 1'b0;
      if (drop && i == nl / 2) req[wi] = 1'b0;
      if (mode == 3 && i == 3) begin
        do_reset();
        return;
      end
      #1;
      chk("act_data", tx_data, ed);
      chk("act_grant", grant, oh);
      chk("act_ack", ack, 0);
      chk("act_to", timeout_err, 0);
      chk("act_send", tx_send, 0);
    end
    if (mode == 2) begin
      tick();
      #1;
      chk("dto_pulse", timeout_err, 1);
      chk("dto_ack", ack, 0);
      tick();
      tx_active = 1'b0;
      #1;
      chk("dto_busy", busy, 0);
      chk("dto_grant", grant, 0);
      cur = -1;
      return;
    end
    tick();
    tx_active = 1'b0;
    tx_done = 1'b1;
    req[wi] = 1'b0;
    cur = -1;
    #1;
    chk("ack", ack, oh);
    chk("ack_to", timeout_err, 0);
    chk("ack_data", tx_data, ed);
    m_last = wi;
    for (int g = 0; g < GAP; g++) begin
      tick();
      tx_done = 1'b0;
      if (rearm && g == 0) req[wi] = 1'b1;
      #1;
      chk("gap_busy", busy, 1);
      chk("gap_grant", grant, 0);
      chk("gap_ack", ack, 0);
    end
    tick();
    tx_done = 1'b0;
    #1;
    chk("end_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    tx_active = 1'b0;
    tx_done = 1'b0;
    arr_en = 1'b0;
    cur = -1;
    m_last = N - 1;
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    dat[0] = 8'hA5;
    req = 4'b0001;
    frame(0, 0, 11, 1'b0, 1'b0, w);
    chk("single_w", w, 0);

    do_reset();
    dat[0] = 8'h11; dat[1] = 8'h22;
    dat[2] = 8'h33; dat[3] = 8'h44;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      frame(0, $urandom_range(0, 3), $urandom_range(1, 12),
            1'b0, 1'b0, w);
      chk("rr_order", w, k);
    end

    do_reset();
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      frame(0, 1, 4, 1'b0, 1'b1, w);
      chk("fair", w, (k % 2 == 0) ? 0 : 2);
    end

    do_reset();
    dat[0] = 8'h5A;
    req = 4'b0001;
    frame(1, 0, 0, 1'b0, 1'b0, w);
    frame(0, 0, 5, 1'b0, 1'b0, w);
    chk("retry_w", w, 0);

    do_reset();
    dat[1] = 8'h3C;
    req = 4'b0010;
    frame(0, 1, 8, 1'b1, 1'b0, w);
    chk("drop_w", w, 1);

    do_reset();
    req = 4'b0001;
    frame(3, 0, 6, 1'b0, 1'b0, w);
    dat[0] = 8'h77;
    dat[3] = 8'h88;
    req = 4'b1001;
    frame(0, 0, 3, 1'b0, 1'b0, w);
    chk("post_rst_pri", w, 0);

    do_reset();
    arr_en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int r;
      int md;
      r = $urandom_range(0, 9);
      md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      frame(md, $urandom_range(0, 3), $urandom_range(1, 12),
            $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), w);
    end
    arr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART serial transmitter (PISO frame shifter) among NUM_REQ byte requesters.
- Picks a requester, presents its byte, and issues a one-cycle send strobe to the transmitter.
- Tracks the transmitter's active/done flags, acknowledges the requester on completion, and inserts an optional idle gap between frames.
- Sits between client logic and the UART Tx datapath. Runs in the baud_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 1, idle baud_clk cycles inserted after each frame before the next grant (0 allowed).
- START_TIMEOUT, 4, max cycles after the send strobe to wait for tx_active=1.
- DONE_TIMEOUT, 16, max cycles in WAIT_DONE before aborting.

Ports:
- baud_clk  in  1  clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until matching ack.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester on frame completion.
- grant  out  NUM_REQ  one-hot current owner; all-zero when not owned.
- tx_send  out  1  one-cycle send strobe to the transmitter.
- tx_data  out  8  byte to the transmitter.
- tx_active  in  1  transmitter active flag.
- tx_done  in  1  transmitter done flag.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on a start or done timeout.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, ack=0, tx_send=0, tx_data=8'h00, busy=0, timeout_err=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), counters=0.
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is set, search from (last_grant+1) mod NUM_REQ upward with wrap; the first set bit wins.
  - On the same edge: set grant to the winner (one-hot), latch tx_data<=req_data[winner], go to SEND.
  - Grant latency is one cycle after req is seen.
- SEND: tx_send=1 for exactly this cycle, counter cleared, go to WAIT_START.
- WAIT_START:
  - tx_active=1 -> go to WAIT_DONE, counter cleared.
  - Otherwise increment the counter. At count==START_TIMEOUT: pulse timeout_err, clear grant, no ack, last_grant unchanged, go to IDLE (same requester is retried next).
- WAIT_DONE:
  - tx_active=0 and tx_done=1 -> pulse ack[grant] for 1 cycle, last_grant<=grant index, grant<=0.
  - Then go to GAP if GAP_CYCLES>0, else to IDLE.
  - Counter reaching DONE_TIMEOUT -> timeout_err pulse, grant<=0, go to IDLE, no ack.
- GAP: count GAP_CYCLES cycles, then go to IDLE. req is ignored during GAP.
- tx_data holds its value from the grant edge until the next grant and never changes mid-frame. tx_send is never asserted outside SEND.
- Requester dropping req mid-frame: the frame still completes and ack is still pulsed. There is no abort.
- Requester re-asserting req in the cycle after its ack: it is treated as a new request and arbitrated round-robin (it goes last if others are pending).
- A new req arriving while busy waits; there is no preemption.
- Simultaneous requests: the winner is determined strictly by rotating priority; every pending requester is served within NUM_REQ grants.
- At most one ack bit is ever high, and only in the cycle leaving WAIT_DONE.
- busy = (state != IDLE).
- Reset mid-frame returns everything to reset values immediately. The transmitter is reset by the same reset_n.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5 -> grant=0001 next cycle, tx_data=A5, tx_send high for 1 cycle. With the transmitter model active for 11 cycles, expect ack[0] for 1 cycle after tx_done, then a 1-cycle GAP, then busy=0.
- All four requesting at once with bytes 11,22,33,44, held until ack -> grants in order 0,1,2,3. tx_data sequence 11,22,33,44. Exactly four ack pulses, one per requester.
- Fairness: req[0] re-asserted immediately after each ack while req[2] stays high -> grants alternate 0,2,0,2. Neither requester is starved.
- Start timeout: the transmitter model never raises tx_active -> timeout_err pulses 5 cycles after tx_send (counts 0..4), no ack, grant cleared. Requester re-granted on the next IDLE cycle.
- Requester drops req[1] mid-frame -> the frame completes, ack[1] still pulses, and tx_data is unchanged throughout.
- reset_n pulled low during WAIT_DONE -> asynchronously grant=0, tx_send=0, ack=0, busy=0, tx_data=00. After release, requester 0 has priority.
